// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory load/store path of the MIPS core.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 10;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: load extract/extend, sub-word store merge and
// alignment check. Purely combinational.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] new_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  chk_addr_lo_i,
  input  logic [1:0]  chk_size_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (size_i)
      SZ_B:    ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_H:    ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: ld_data_o = word_i;
    endcase
  end

  // Sub-word stores keep the old word and overwrite only the addressed lane.
  always_comb begin
    st_word_o = word_i;
    case (size_i)
      SZ_B: begin
        case (addr_lo_i)
          2'd0:    st_word_o[7:0]   = new_i[7:0];
          2'd1:    st_word_o[15:8]  = new_i[7:0];
          2'd2:    st_word_o[23:16] = new_i[7:0];
          default: st_word_o[31:24] = new_i[7:0];
        endcase
      end
      SZ_H: begin
        if (addr_lo_i[1]) st_word_o[31:16] = new_i[15:0];
        else              st_word_o[15:0]  = new_i[15:0];
      end
      default: st_word_o = new_i;
    endcase
  end

  assign misaligned_o = (chk_size_i == 2'b11)
                      | ((chk_size_i == SZ_H) & chk_addr_lo_i[0])
                      | ((chk_size_i == SZ_W) & (|chk_addr_lo_i));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory. One request at a
// time; sub-word stores are done as read-modify-write.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output state_t            dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; a response transfers where rsp_valid and rsp_ready
  // are both 1. Valid is never withdrawn by this unit before its transfer.

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                dm_wr_q, dm_wr_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [31:0]         dm_wdata_q, dm_wdata_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        misaligned;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  mem_lane_align u_align (
    .word_i        (dm_rdata),
    .new_i         (wdata_q),
    .addr_lo_i     (addr_lo_q),
    .size_i        (size_q),
    .signed_i      (signed_q),
    .chk_addr_lo_i (req_addr[1:0]),
    .chk_size_i    (req_size),
    .ld_data_o     (ld_data),
    .st_word_o     (st_word),
    .misaligned_o  (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    addr_lo_d  = addr_lo_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    dm_wr_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          size_d    = req_size;
          signed_d  = req_signed;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata;
          err_d     = misaligned;
          rdata_d   = 32'd0;
          if (misaligned) begin
            state_d = ST_RESP;
          end else begin
            dm_addr_d = req_addr[ADDR_W+1:2];
            if (req_we && (req_size == SZ_W)) begin
              state_d    = ST_WR;
              dm_wr_d    = 1'b1;
              dm_wdata_d = req_wdata;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (we_q) begin
          state_d    = ST_WR;
          dm_wr_d    = 1'b1;
          dm_wdata_d = st_word;
        end else begin
          state_d = ST_LDW;
        end
      end
      ST_LDW: begin
        rdata_d = ld_data;
        state_d = ST_RESP;
      end
      ST_WR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      signed_q   <= 1'b0;
      addr_lo_q  <= 2'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      dm_wr_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      addr_lo_q  <= addr_lo_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      dm_wr_q    <= dm_wr_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dm_wr     = dm_wr_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan steps plus random traffic,
// checked against a byte-array reference of the data memory.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  state_t        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dm_wr      (dm_wr),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dbg_state  (dbg_state)
  );

  // data memory attached to the DUT port; read data is garbage while writing
  logic [31:0] tb_mem [0:WORDS-1];
  always @(posedge clk) if (dm_wr) tb_mem[dm_addr] <= dm_wdata;
  assign dm_rdata = dm_wr ? 32'hA5A5_5A5A : tb_mem[dm_addr];

  int            wr_cnt = 0;
  logic [AW-1:0] last_wr_addr;
  logic [31:0]   last_wr_data;
  always @(negedge clk) begin
    if (dm_wr) begin
      wr_cnt++;
      last_wr_addr = dm_addr;
      last_wr_data = dm_wdata;
    end
  end

  // reference model: memory as a flat byte array
  logic [7:0] ref_mem [0:4*WORDS-1];
  logic [31:0] exp_q [$];

  int checks = 0;
  int failures = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int ref_bad(input logic [1:0] size, input int addr);
    if (size == 2'b11) return 1;
    if (size == 2'b01 && (addr % 2) != 0) return 1;
    if (size == 2'b10 && (addr % 4) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input int addr, input logic [1:0] size, input logic sgn);
    int n;
    longint val;
    n = 1 << size;
    val = 0;
    for (int i = 0; i < n; i++) val = val + (longint'(ref_mem[addr + i]) << (8 * i));
    if (sgn && n < 4 && ((val >> (8 * n - 1)) & 1) == 1) val = val + 64'hFFFF_FFFF - ((longint'(1) << (8 * n)) - 1);
    return val[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_mem[4*wa+3], ref_mem[4*wa+2], ref_mem[4*wa+1], ref_mem[4*wa]};
  endfunction

  // driver: one request, full response check, optional backpressure
  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int a, bad, exp_lat, exp_wr, lat, w0, wait_n;
    logic [31:0] exp_rd;
    a = int'(addr[AW+1:0]);
    bad = ref_bad(size, a);
    exp_rd = (!we && bad == 0) ? ref_load(a, size, sgn) : 32'd0;
    exp_lat = (bad != 0) ? 1 : ((we && size == SZ_W) ? 2 : 3);
    exp_wr = (we && bad == 0) ? 1 : 0;
    if (exp_wr != 0) begin
      for (int i = 0; i < (1 << size); i++) ref_mem[a + i] = wdata[8*i +: 8];
    end
    exp_q.push_back(exp_rd);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
    check32({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check32({tag, ".latency"}, lat, exp_lat);
    check32({tag, ".rsp_err"}, {31'd0, rsp_err}, bad);
    check32({tag, ".rsp_rdata"}, rsp_rdata, exp_q.pop_front());
    check32({tag, ".dm_wr_cycles"}, wr_cnt - w0, exp_wr);
    if (exp_wr != 0) begin
      check32({tag, ".dm_addr"}, {22'd0, last_wr_addr}, a / 4);
      check32({tag, ".dm_wdata"}, last_wr_data, ref_word(a / 4));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check32({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check32({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
      check32({tag, ".hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check32({tag, ".done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check32({tag, ".done_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int w0;
    logic [31:0] r;
    for (int w = 0; w < WORDS; w++) begin
      r = $urandom;
      tb_mem[w] = r;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = r[8*b +: 8];
    end

    // reset values
    #12;
    check32("reset.req_ready", {31'd0, req_ready}, 32'd1);
    check32("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("reset.dm_wr", {31'd0, dm_wr}, 32'd0);
    check32("reset.dm_addr", {22'd0, dm_addr}, 32'd0);
    check32("reset.dm_wdata", dm_wdata, 32'd0);
    check32("reset.state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of a sub-word store's RD cycle: no write may follow
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h77;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    check32("rst_mid.in_rd_dm_addr", {22'd0, dm_addr}, 32'h8);
    rst_n = 1'b0;
    #1;
    check32("rst_mid.req_ready", {31'd0, req_ready}, 32'd1);
    check32("rst_mid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("rst_mid.rsp_rdata", rsp_rdata, 32'd0);
    check32("rst_mid.rsp_err", {31'd0, rsp_err}, 32'd0);
    check32("rst_mid.dm_wr", {31'd0, dm_wr}, 32'd0);
    check32("rst_mid.dm_addr", {22'd0, dm_addr}, 32'd0);
    check32("rst_mid.dm_wdata", dm_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check32("rst_mid.no_write", wr_cnt - w0, 32'd0);
    check32("rst_mid.no_rsp", {31'd0, rsp_valid}, 32'd0);
    check32("rst_mid.mem_kept", tb_mem[8], ref_word(8));

    // word store / load
    do_req("sw_10", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    check32("sw_10.mem", tb_mem[4], 32'hDEADBEEF);
    do_req("lw_10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 0);

    // byte store / load
    do_req("sw_init", 1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 0);
    do_req("sb_11", 1'b1, SZ_B, 1'b0, 32'h11, 32'h000000AB, 0);
    check32("sb_11.mem", tb_mem[4], 32'h1122AB44);
    do_req("lb_11", 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 0);
    do_req("lbu_11", 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 0);

    // half store / load
    do_req("sh_12", 1'b1, SZ_H, 1'b0, 32'h12, 32'h00008001, 0);
    check32("sh_12.mem", tb_mem[4], 32'h8001AB44);
    do_req("lh_12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 0);
    do_req("lhu_12", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 0);

    // misaligned and illegal
    do_req("lw_13", 1'b0, SZ_W, 1'b0, 32'h13, 32'h0, 0);
    do_req("sh_11", 1'b1, SZ_H, 1'b0, 32'h11, 32'h5555, 0);
    do_req("sz_11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    check32("misalign.mem_kept", tb_mem[4], 32'h8001AB44);

    // backpressure, then an immediate next request
    do_req("bp_lw", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 5);
    do_req("bp_next", 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 0);

    // random traffic over a small window so loads see earlier stores
    for (int i = 0; i < 60; i++) begin
      do_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) | ($urandom & 32'hFFFF_F000),
             $urandom, $urandom_range(0, 2));
    end
    for (int w = 0; w < 16; w++) check32($sformatf("final.mem%0d", w), tb_mem[w], ref_word(w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
